mem_arbiter: RTL and testbench

- Shares the single-port synchronous MEMORY between two requesters: the cpu (primary) and a secondary DMA/video master.
- Each cycle it grants at most one requester and muxes that requester's address, write enable and write data onto the memory port.
- Read data returns one cycle after grant, tagged to the original requester.
- The cpu has fixed priority, bounded by a starvation guard for the DMA and a lock for cpu read-modify-write sequences.

---
 rtl/mem_arbiter_if.sv | 60 ++++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (cpu, dma) and the
// single-port synchronous memory.
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata valid in the same
// cycle; the access happens in every cycle where *_req && *_gnt (gnt is
// combinational, so an ungranted requester simply retries next cycle); read data
// comes back on *_rvalid/*_rdata exactly one cycle after the granted read, with
// no back-pressure on the return path.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_lock;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Internal arbitration state made visible for observation.
  logic [3:0]        dbg_wait_cnt;
  logic              dbg_lock_act;
  logic [3:0]        dbg_lock_cnt;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_we, mem_din,
    output dbg_wait_cnt, dbg_lock_act, dbg_lock_cnt
  );

  // Requester / memory side.
  modport master (
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_we, mem_din,
    input  dbg_wait_cnt, dbg_lock_act, dbg_lock_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between a fixed-priority
// cpu and a secondary DMA master. A starvation guard forces a DMA slot after
// MAX_WAIT denied cycles, and a cpu lock holds the port for read-modify-write
// sequences for at most 1 + LOCK_MAX cycles. Read data is tagged to its owner
// and returned one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic          CLK,
  input  logic          R,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              lock_act_q, lock_act_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic [1:0]        rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic              cpu_gnt;
  logic              dma_gnt;
  logic              lock_rule;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_din;

  // Grant selection: lock continuation, DMA starvation guard, cpu, DMA; none in reset.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    lock_rule = 1'b0;
    if (R) begin
      if (lock_act_q && bus.cpu_req && (lock_cnt_q < LOCK_MAX_C)) begin
        cpu_gnt   = 1'b1;
        lock_rule = 1'b1;
      end else if (bus.dma_req && (wait_cnt_q == MAX_WAIT_C)) begin
        dma_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // Memory port mux: granted requester drives the port, otherwise park on last address.
  always_comb begin
    sel_addr = last_addr_q;
    sel_we   = 1'b0;
    sel_din  = '0;
    if (cpu_gnt) begin
      sel_addr = bus.cpu_addr;
      sel_we   = bus.cpu_we;
      sel_din  = bus.cpu_wdata;
    end else if (dma_gnt) begin
      sel_addr = bus.dma_addr;
      sel_we   = bus.dma_we;
      sel_din  = bus.dma_wdata;
    end
  end

  // Next-state for starvation counter, lock tracking, read owner and parked address.
  always_comb begin
    last_addr_d = last_addr_q;
    if (cpu_gnt || dma_gnt) begin
      last_addr_d = sel_addr;
    end

    if (dma_gnt || !bus.dma_req) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // The lock drops as soon as the cpu stops asking for it or the DMA gets in.
    if (!bus.cpu_req || !bus.cpu_lock || dma_gnt) begin
      lock_act_d = 1'b0;
    end else if (cpu_gnt) begin
      lock_act_d = 1'b1;
    end else begin
      lock_act_d = lock_act_q;
    end

    // Counts only grants obtained through the lock; it is meaningless without a lock.
    if (!lock_act_d) begin
      lock_cnt_d = 4'd0;
    end else if (lock_rule && (lock_cnt_q < LOCK_MAX_C)) begin
      lock_cnt_d = lock_cnt_q + 4'd1;
    end else begin
      lock_cnt_d = lock_cnt_q;
    end

    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && !bus.dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!R) begin
      wait_cnt_q  <= 4'd0;
      lock_act_q  <= 1'b0;
      lock_cnt_q  <= 4'd0;
      rd_owner_q  <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      lock_act_q  <= lock_act_d;
      lock_cnt_q  <= lock_cnt_d;
      rd_owner_q  <= rd_owner_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.dma_gnt      = dma_gnt;
  assign bus.mem_addr     = sel_addr;
  assign bus.mem_we       = sel_we;
  assign bus.mem_din      = sel_din;
  assign bus.cpu_rvalid   = (rd_owner_q == OWN_CPU);
  assign bus.dma_rvalid   = (rd_owner_q == OWN_DMA);
  assign bus.cpu_rdata    = bus.mem_dout;
  assign bus.dma_rdata    = bus.mem_dout;
  assign bus.dbg_wait_cnt = wait_cnt_q;
  assign bus.dbg_lock_act = lock_act_q;
  assign bus.dbg_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run, all checked
// against a behavioural model (integer counters, a reference memory and an
// expected read-data queue) kept in this file.
module tb_mem_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic R;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .CLK(CLK),
    .R  (R),
    .bus(mif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Unwritten locations hold a fixed address-derived pattern.
  function automatic logic [DATA_W-1:0] mem_init(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // ---------------- memory attached to the DUT ----------------
  logic [DATA_W-1:0] tb_mem [logic [ADDR_W-1:0]];
  always @(posedge CLK) begin
    logic [DATA_W-1:0] rd;
    rd = tb_mem.exists(mif.mem_addr) ? tb_mem[mif.mem_addr] : mem_init(mif.mem_addr);
    if (mif.mem_we) tb_mem[mif.mem_addr] = mif.mem_din;
    mif.mem_dout <= rd;
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] exp_q[$];
  int                m_wait = 0;
  bit                m_locked = 0;
  int                m_lock_len = 0;
  int                m_rd = 0;          // 0 none, 1 cpu, 2 dma
  logic [ADDR_W-1:0] m_last = '0;

  int                e_who;
  bit                e_by_lock;
  logic              e_cpu_gnt, e_dma_gnt, e_we, e_cpu_rv, e_dma_rv;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_din, e_rdata;

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  // Expected outputs for the current cycle from the model state and current inputs.
  function automatic void model_eval();
    e_who = 0;
    e_by_lock = 0;
    if (R === 1'b1) begin
      if (m_locked && mif.cpu_req && m_lock_len < LOCK_MAX) begin
        e_who = 1; e_by_lock = 1;
      end else if (mif.dma_req && m_wait >= MAX_WAIT) e_who = 2;
      else if (mif.cpu_req) e_who = 1;
      else if (mif.dma_req) e_who = 2;
    end
    e_cpu_gnt = (e_who == 1);
    e_dma_gnt = (e_who == 2);
    case (e_who)
      1: begin e_addr = mif.cpu_addr; e_we = mif.cpu_we; e_din = mif.cpu_wdata; end
      2: begin e_addr = mif.dma_addr; e_we = mif.dma_we; e_din = mif.dma_wdata; end
      default: begin e_addr = m_last; e_we = 1'b0; e_din = '0; end
    endcase
    e_cpu_rv = (m_rd == 1);
    e_dma_rv = (m_rd == 2);
    e_rdata  = (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  // Advance the model across one rising edge.
  function automatic void model_commit();
    if (m_rd != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    if (R !== 1'b1) begin
      m_wait = 0; m_locked = 0; m_lock_len = 0; m_rd = 0; m_last = '0;
      exp_q.delete();
    end else begin
      m_rd = 0;
      if (e_who != 0) begin
        m_last = e_addr;
        if (e_we) ref_mem[e_addr] = e_din;
        else begin
          m_rd = e_who;
          exp_q.push_back(ref_read(e_addr));
        end
      end
      if (e_dma_gnt || !mif.dma_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (!mif.cpu_req || !mif.cpu_lock || e_dma_gnt) begin
        m_locked = 0; m_lock_len = 0;
      end else if (e_cpu_gnt) begin
        m_locked = 1;
        if (e_by_lock && m_lock_len < LOCK_MAX) m_lock_len++;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit c_req, input bit c_we, input bit c_lock,
                       input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_wd,
                       input bit d_req, input bit d_we,
                       input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_wd);
    mif.cpu_req = c_req; mif.cpu_we = c_we; mif.cpu_lock = c_lock;
    mif.cpu_addr = c_addr; mif.cpu_wdata = c_wd;
    mif.dma_req = d_req; mif.dma_we = d_we; mif.dma_addr = d_addr; mif.dma_wdata = d_wd;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic settle();
    @(negedge CLK);
    model_eval();
  endtask

  task automatic advance();
    model_eval();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    R = 1'b0;
    drive(1, 1, 1, 16'h1111, 8'h11, 1, 1, 16'h2222, 8'h22);
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if ({mif.cpu_gnt, mif.dma_gnt, mif.mem_we} !== 3'b000) begin
        n_errors++;
        $display("FAIL rst_forced cyc %0d: gnt/we got %b expected 000", i,
                 {mif.cpu_gnt, mif.dma_gnt, mif.mem_we});
      end
      advance();
    end
    settle();
    n_checks++;
    if ({mif.cpu_rvalid, mif.dma_rvalid, mif.dbg_lock_act, mif.dbg_wait_cnt, mif.dbg_lock_cnt} !== 11'd0) begin
      n_errors++;
      $display("FAIL rst_state: rv %b%b lock_act %b wait %0d lock_cnt %0d expected all 0",
               mif.cpu_rvalid, mif.dma_rvalid, mif.dbg_lock_act, mif.dbg_wait_cnt, mif.dbg_lock_cnt);
    end
    n_checks++;
    if (mif.mem_addr !== 16'h0000) begin
      n_errors++;
      $display("FAIL rst_addr: got %h expected 0000", mif.mem_addr);
    end
    R = 1'b1;
    drive_idle();
    advance();
  endtask

  task automatic test_cpu_read();
    drive(1, 0, 0, 16'h1234, 8'h00, 0, 0, '0, '0);
    settle();
    n_checks++;
    if ({mif.cpu_gnt, mif.dma_gnt, mif.mem_we} !== 3'b100 || mif.mem_addr !== 16'h1234) begin
      n_errors++;
      $display("FAIL cpu_rd_gnt: gnt/we %b addr %h expected 100 addr 1234",
               {mif.cpu_gnt, mif.dma_gnt, mif.mem_we}, mif.mem_addr);
    end
    advance();
    drive_idle();
    settle();
    n_checks++;
    if ({mif.cpu_rvalid, mif.dma_rvalid} !== 2'b10 || mif.cpu_rdata !== mem_init(16'h1234)) begin
      n_errors++;
      $display("FAIL cpu_rd_ret: rv %b data %h expected rv 10 data %h",
               {mif.cpu_rvalid, mif.dma_rvalid}, mif.cpu_rdata, mem_init(16'h1234));
    end
    advance();
  endtask

  task automatic test_contention();
    for (int i = 0; i < 15; i++) begin
      bit exp_dma;
      exp_dma = ((i % 5) == 4);
      drive(1, 0, 0, 16'h0100 + 16'(i), 8'h00, 1, 0, 16'h0800 + 16'(i), 8'h00);
      settle();
      n_checks++;
      if ({mif.cpu_gnt, mif.dma_gnt} !== {!exp_dma, exp_dma} || mif.dbg_wait_cnt !== 4'(i % 5)) begin
        n_errors++;
        $display("FAIL contend cyc %0d: gnt %b wait %0d expected gnt %b wait %0d", i,
                 {mif.cpu_gnt, mif.dma_gnt}, mif.dbg_wait_cnt, {!exp_dma, exp_dma}, i % 5);
      end
      n_checks++;
      if ({mif.cpu_rvalid, mif.dma_rvalid} !== {e_cpu_rv, e_dma_rv} ||
          ((e_cpu_rv || e_dma_rv) && mif.cpu_rdata !== e_rdata)) begin
        n_errors++;
        $display("FAIL contend_rd cyc %0d: rv %b data %h expected rv %b data %h", i,
                 {mif.cpu_rvalid, mif.dma_rvalid}, mif.cpu_rdata, {e_cpu_rv, e_dma_rv}, e_rdata);
      end
      advance();
    end
    drive_idle();
    advance();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 12; i++) begin
      bit exp_cpu;
      exp_cpu = (i != 9);
      drive(1, 1, 1, 16'h0200, 8'hA5, 1, 0, 16'h0300, 8'h00);
      settle();
      n_checks++;
      if ({mif.cpu_gnt, mif.dma_gnt} !== {exp_cpu, !exp_cpu} || mif.mem_we !== exp_cpu) begin
        n_errors++;
        $display("FAIL lock_gnt cyc %0d: gnt %b we %b expected gnt %b we %b", i,
                 {mif.cpu_gnt, mif.dma_gnt}, mif.mem_we, {exp_cpu, !exp_cpu}, exp_cpu);
      end
      n_checks++;
      if (mif.mem_addr !== (exp_cpu ? 16'h0200 : 16'h0300) || (exp_cpu && mif.mem_din !== 8'hA5)) begin
        n_errors++;
        $display("FAIL lock_port cyc %0d: addr %h din %h", i, mif.mem_addr, mif.mem_din);
      end
      n_checks++;
      if ({mif.cpu_rvalid, mif.dma_rvalid} !== {1'b0, (i == 10)}) begin
        n_errors++;
        $display("FAIL lock_rv cyc %0d: got %b expected %b", i,
                 {mif.cpu_rvalid, mif.dma_rvalid}, {1'b0, (i == 10)});
      end
      advance();
    end
    drive_idle();
    advance();
  endtask

  task automatic test_back_to_back();
    logic [1:0] rv_tab [4];
    rv_tab = '{2'b00, 2'b01, 2'b10, 2'b00};   // {cpu_rvalid, dma_rvalid}
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(0, 0, 0, '0, '0, 1, 0, 16'h00FF, '0);
      else if (i == 1) drive(1, 0, 0, 16'h0010, '0, 0, 0, '0, '0);
      else drive_idle();
      settle();
      n_checks++;
      if ({mif.cpu_rvalid, mif.dma_rvalid} !== rv_tab[i]) begin
        n_errors++;
        $display("FAIL b2b_rv cyc %0d: got %b expected %b", i, {mif.cpu_rvalid, mif.dma_rvalid}, rv_tab[i]);
      end
      if (i == 1 || i == 2) begin
        logic [DATA_W-1:0] want;
        want = mem_init((i == 1) ? 16'h00FF : 16'h0010);
        n_checks++;
        if (((i == 1) ? mif.dma_rdata : mif.cpu_rdata) !== want) begin
          n_errors++;
          $display("FAIL b2b_data cyc %0d: got %h expected %h", i,
                   (i == 1) ? mif.dma_rdata : mif.cpu_rdata, want);
        end
      end
      advance();
    end
  endtask

  task automatic test_idle_hold();
    drive(1, 1, 0, 16'h4000, 8'h3C, 0, 0, '0, '0);
    advance();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (mif.mem_addr !== 16'h4000 || {mif.mem_we, mif.cpu_gnt, mif.dma_gnt, mif.cpu_rvalid, mif.dma_rvalid} !== 5'd0
          || mif.mem_din !== 8'h00) begin
        n_errors++;
        $display("FAIL idle_hold cyc %0d: addr %h din %h we/gnt/rv %b expected 4000 00 00000", i,
                 mif.mem_addr, mif.mem_din,
                 {mif.mem_we, mif.cpu_gnt, mif.dma_gnt, mif.cpu_rvalid, mif.dma_rvalid});
      end
      advance();
    end
    drive(0, 0, 0, '0, '0, 1, 0, 16'h4000, '0);
    advance();
    drive_idle();
    settle();
    n_checks++;
    if (mif.dma_rvalid !== 1'b1 || mif.dma_rdata !== 8'h3C) begin
      n_errors++;
      $display("FAIL raw_read: rv %b data %h expected 1 3c", mif.dma_rvalid, mif.dma_rdata);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 16'h0500, '0, 1, 0, 16'h0600, '0);
      advance();
    end
    settle();
    n_checks++;
    if ({mif.dbg_lock_act, mif.dbg_lock_cnt, mif.dbg_wait_cnt} !== {1'b1, 4'd2, 4'd3}) begin
      n_errors++;
      $display("FAIL pre_rst_state: lock %b cnt %0d wait %0d expected 1 2 3",
               mif.dbg_lock_act, mif.dbg_lock_cnt, mif.dbg_wait_cnt);
    end
    R = 1'b0;
    advance();
    R = 1'b1;
    drive(0, 0, 0, '0, '0, 1, 0, 16'h00FF, '0);
    settle();
    n_checks++;
    if ({mif.dbg_lock_act, mif.dbg_lock_cnt, mif.dbg_wait_cnt, mif.cpu_rvalid} !== 10'd0 || mif.dma_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_clear: lock %b cnt %0d wait %0d cpu_rv %b dma_gnt %b expected 0 0 0 0 1",
               mif.dbg_lock_act, mif.dbg_lock_cnt, mif.dbg_wait_cnt, mif.cpu_rvalid, mif.dma_gnt);
    end
    advance();
    R = 1'b0;
    drive(1, 0, 1, 16'h0700, '0, 1, 1, 16'h0710, 8'h77);
    settle();
    n_checks++;
    if ({mif.cpu_gnt, mif.dma_gnt, mif.mem_we, mif.dma_rvalid} !== 4'b0001) begin
      n_errors++;
      $display("FAIL rst_mid_forced: gnt/we/dma_rv %b expected 0001",
               {mif.cpu_gnt, mif.dma_gnt, mif.mem_we, mif.dma_rvalid});
    end
    advance();
    R = 1'b1;
    drive_idle();
    settle();
    n_checks++;
    if ({mif.dma_rvalid, mif.cpu_rvalid, mif.cpu_gnt, mif.dma_gnt, mif.dbg_wait_cnt, mif.dbg_lock_cnt} !== 12'd0) begin
      n_errors++;
      $display("FAIL rst_mid_after: dma_rv %b cpu_rv %b wait %0d lock_cnt %0d expected 0",
               mif.dma_rvalid, mif.cpu_rvalid, mif.dbg_wait_cnt, mif.dbg_lock_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int phase;
      phase = i / 150;   // vary request/lock pressure across the run
      R = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 9) < ((phase == 1) ? 9 : 6),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < ((phase >= 2) ? 8 : 3),
            16'h0700 + 16'($urandom_range(0, 15)), 8'($urandom),
            $urandom_range(0, 9) < ((phase == 3) ? 9 : 5),
            $urandom_range(0, 2) == 0,
            16'h0700 + 16'($urandom_range(0, 15)), 8'($urandom));
      settle();
      n_checks++;
      if ({mif.cpu_gnt, mif.dma_gnt} !== {e_cpu_gnt, e_dma_gnt}) begin
        n_errors++;
        $display("FAIL rnd_gnt cyc %0d: got %b expected %b", i,
                 {mif.cpu_gnt, mif.dma_gnt}, {e_cpu_gnt, e_dma_gnt});
      end
      n_checks++;
      if (mif.mem_addr !== e_addr || mif.mem_we !== e_we || mif.mem_din !== e_din) begin
        n_errors++;
        $display("FAIL rnd_port cyc %0d: addr %h we %b din %h expected %h %b %h", i,
                 mif.mem_addr, mif.mem_we, mif.mem_din, e_addr, e_we, e_din);
      end
      n_checks++;
      if ({mif.cpu_rvalid, mif.dma_rvalid} !== {e_cpu_rv, e_dma_rv} ||
          (e_cpu_rv && mif.cpu_rdata !== e_rdata) || (e_dma_rv && mif.dma_rdata !== e_rdata)) begin
        n_errors++;
        $display("FAIL rnd_read cyc %0d: rv %b cpu %h dma %h expected rv %b data %h", i,
                 {mif.cpu_rvalid, mif.dma_rvalid}, mif.cpu_rdata, mif.dma_rdata,
                 {e_cpu_rv, e_dma_rv}, e_rdata);
      end
      n_checks++;
      if (mif.dbg_wait_cnt !== 4'(m_wait) || mif.dbg_lock_act !== m_locked ||
          mif.dbg_lock_cnt !== 4'(m_lock_len)) begin
        n_errors++;
        $display("FAIL rnd_state cyc %0d: wait %0d lock %b cnt %0d expected %0d %b %0d", i,
                 mif.dbg_wait_cnt, mif.dbg_lock_act, mif.dbg_lock_cnt, m_wait, m_locked, m_lock_len);
      end
      advance();
    end
    R = 1'b1;
    drive_idle();
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    R = 1'b0;
    drive_idle();
    test_reset();
    test_cpu_read();
    test_contention();
    test_lock();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
